// File: rtl/barrel_sched_pkg.sv
// Shared types and pass-size helpers for the barrel rotate scheduler.
package barrel_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROT,
        CAPT,
        RESP
    } state_t;

    localparam int unsigned SEL_W_DEF = 3;
    localparam int unsigned STEP      = 2 ** SEL_W_DEF;

    // Size of the next barrel pass: never more than one full Select range.
    function automatic int unsigned min_step(input int unsigned rem,
                                             input int unsigned step = STEP);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/barrel_rr_arb2.sv
// Two-way round-robin arbiter; the last-granted pointer moves only on an accepted grant.
module barrel_rr_arb2 (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_q;

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    // Reset value 1 means "requester 1 went last", so requester 0 wins the first tie.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/barrel_rotate_sched.sv
// Schedules rotate-left requests from two requesters onto one shared registered barrel.
// Optional BARREL_SCHED_STATS_EN adds per-requester saturating completion counters.
//
// state | meaning
// IDLE  | waiting for a request; Req_ready carries the arbiter grant
// LOAD  | first pass: barrel loads the latched word and rotates by step
// ROT   | further passes on the barrel's own contents
// CAPT  | barrel output holds the finished word; capture it
// RESP  | response presented until Rsp_ready
module barrel_rotate_sched
    import barrel_sched_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SEL_W     = 3,
    parameter int AMT_W     = 6
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [1:0]           Req_valid,
    output logic [1:0]           Req_ready,
    input  logic [DATA_SIZE-1:0] Req_data_0,
    input  logic [DATA_SIZE-1:0] Req_data_1,
    input  logic [AMT_W-1:0]     Req_amt_0,
    input  logic [AMT_W-1:0]     Req_amt_1,
    output logic                 Rsp_valid,
    input  logic                 Rsp_ready,
    output logic                 Rsp_id,
    output logic [DATA_SIZE-1:0] Rsp_data,
`ifdef BARREL_SCHED_STATS_EN
    output logic [15:0]          Stat_done_0,
    output logic [15:0]          Stat_done_1,
`endif
    output logic                 Br_load,
    output logic [SEL_W-1:0]     Br_select,
    output logic [DATA_SIZE-1:0] Br_data_in,
    input  logic [DATA_SIZE-1:0] Br_data_out
);

    localparam int RW     = $clog2(DATA_SIZE) + 1;
    localparam int STEP_L = 1 << SEL_W;

    state_t               state_q, state_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 id_q, id_d;
    logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [DATA_SIZE-1:0] br_din_q, br_din_d;
    logic                 active_q;

    logic [1:0]           grant;
    logic                 accept;
    logic [DATA_SIZE-1:0] sel_data;
    logic [AMT_W-1:0]     sel_amt;
    logic [RW-1:0]        r_sel;
    int unsigned          step;
    logic [RW-1:0]        step_w;

    // active_q keeps Req_ready low while Reset is asserted, even though the FSM sits in IDLE.
    assign accept   = (state_q == IDLE) && active_q && (grant != 2'b00);
    assign sel_data = grant[1] ? Req_data_1 : Req_data_0;
    assign sel_amt  = grant[1] ? Req_amt_1 : Req_amt_0;
    assign r_sel    = RW'(int'(sel_amt) % DATA_SIZE);
    assign step     = min_step(int'(rem_q), STEP_L);
    assign step_w   = RW'(step);

    barrel_rr_arb2 u_arb (
        .Clock    (Clock),
        .Reset    (Reset),
        .valid_i  (Req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        data_d     = data_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        br_din_d   = br_din_q;
        Req_ready  = 2'b00;
        Rsp_valid  = 1'b0;
        Br_load    = 1'b0;
        Br_select  = '0;
        Br_data_in = br_din_q;
        case (state_q)
            IDLE: begin
                Req_ready = active_q ? grant : 2'b00;
                if (accept) begin
                    data_d = sel_data;
                    id_d   = grant[1];
                    rem_d  = r_sel;
                    if (r_sel == '0) begin
                        rsp_data_d = sel_data;
                        rsp_id_d   = grant[1];
                        state_d    = RESP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                Br_load    = 1'b1;
                Br_data_in = data_q;
                br_din_d   = data_q;
                Br_select  = SEL_W'(step - 1);
                rem_d      = rem_q - step_w;
                state_d    = (rem_d != '0) ? ROT : CAPT;
            end
            ROT: begin
                Br_select = SEL_W'(step - 1);
                rem_d     = rem_q - step_w;
                state_d   = (rem_d != '0) ? ROT : CAPT;
            end
            CAPT: begin
                rsp_data_d = Br_data_out;
                rsp_id_d   = id_q;
                state_d    = RESP;
            end
            RESP: begin
                Rsp_valid = 1'b1;
                if (Rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            data_q     <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            br_din_q   <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            br_din_q   <= br_din_d;
            active_q   <= 1'b1;
        end
    end

    assign Rsp_data = rsp_data_q;
    assign Rsp_id   = rsp_id_q;

`ifdef BARREL_SCHED_STATS_EN
    logic        rsp_done;
    logic [15:0] done0_q, done1_q;

    assign rsp_done = (state_q == RESP) && Rsp_ready;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            done0_q <= '0;
            done1_q <= '0;
        end else if (rsp_done) begin
            if (!rsp_id_q && done0_q != 16'hFFFF) done0_q <= done0_q + 16'd1;
            if (rsp_id_q && done1_q != 16'hFFFF)  done1_q <= done1_q + 16'd1;
        end
    end

    assign Stat_done_0 = done0_q;
    assign Stat_done_1 = done1_q;
`endif

endmodule

// File: tb/tb_barrel_rotate_sched.sv
// Directed bench for barrel_rotate_sched: default instance plus a SEL_W=2 instance, each with a barrel model.
module tb_barrel_rotate_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] req_valid, req_ready;
    logic [7:0] d0, d1;
    logic [5:0] a0, a1;
    logic       rsp_ready, rsp_valid, rsp_id;
    logic [7:0] rsp_data;
    logic       br_load;
    logic [2:0] br_sel;
    logic [7:0] br_din, br_q;

    logic [1:0] req_valid2, req_ready2;
    logic [7:0] d02, d12;
    logic [5:0] a02, a12;
    logic       rsp_ready2, rsp_valid2, rsp_id2;
    logic [7:0] rsp_data2;
    logic       br_load2;
    logic [1:0] br_sel2;
    logic [7:0] br_din2, br2_q;

`ifdef BARREL_SCHED_STATS_EN
    logic [15:0] st0, st1, st0_2, st1_2;
`endif

    barrel_rotate_sched u_dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .Req_valid   (req_valid),
        .Req_ready   (req_ready),
        .Req_data_0  (d0),
        .Req_data_1  (d1),
        .Req_amt_0   (a0),
        .Req_amt_1   (a1),
        .Rsp_valid   (rsp_valid),
        .Rsp_ready   (rsp_ready),
        .Rsp_id      (rsp_id),
        .Rsp_data    (rsp_data),
`ifdef BARREL_SCHED_STATS_EN
        .Stat_done_0 (st0),
        .Stat_done_1 (st1),
`endif
        .Br_load     (br_load),
        .Br_select   (br_sel),
        .Br_data_in  (br_din),
        .Br_data_out (br_q)
    );

    barrel_rotate_sched #(.DATA_SIZE(8), .SEL_W(2), .AMT_W(6)) u_dut2 (
        .Clock       (clk),
        .Reset       (rst_n),
        .Req_valid   (req_valid2),
        .Req_ready   (req_ready2),
        .Req_data_0  (d02),
        .Req_data_1  (d12),
        .Req_amt_0   (a02),
        .Req_amt_1   (a12),
        .Rsp_valid   (rsp_valid2),
        .Rsp_ready   (rsp_ready2),
        .Rsp_id      (rsp_id2),
        .Rsp_data    (rsp_data2),
`ifdef BARREL_SCHED_STATS_EN
        .Stat_done_0 (st0_2),
        .Stat_done_1 (st1_2),
`endif
        .Br_load     (br_load2),
        .Br_select   (br_sel2),
        .Br_data_in  (br_din2),
        .Br_data_out (br2_q)
    );

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    initial begin
        br_q  = 8'h00;
        br2_q = 8'h00;
    end

    always @(posedge clk) begin
        br_q  <= rotl8(br_load ? br_din : br_q, int'(br_sel) + 1);
        br2_q <= rotl8(br_load2 ? br_din2 : br2_q, int'(br_sel2) + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] eg;
        logic [7:0] ed;
        rst_n      = 1'b0;
        req_valid  = 2'b00; d0 = 8'h00; d1 = 8'h00; a0 = 6'd0; a1 = 6'd0; rsp_ready = 1'b0;
        req_valid2 = 2'b00; d02 = 8'h00; d12 = 8'h00; a02 = 6'd0; a12 = 6'd0; rsp_ready2 = 1'b0;

        // reset state
        tick;
        tick;
        req_valid = 2'b01;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_br_load", br_load, 1'b0);
        check("rst_br_sel", br_sel, 3'd0);
        check("rst_br_din", br_din, 8'h00);
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick;

        // req0 0x14 rotl 3: one pass, response in cycle 3
        req_valid = 2'b01; d0 = 8'h14; a0 = 6'd3;
        #1;
        check("t1_grant", req_ready, 2'b01);
        tick;
        req_valid = 2'b00;
        #1;
        check("t1_load", br_load, 1'b1);
        check("t1_sel", br_sel, 3'd2);
        check("t1_din", br_din, 8'h14);
        check("t1_ready_busy", req_ready, 2'b00);
        tick;
        check("t1_capt_load", br_load, 1'b0);
        check("t1_capt_valid", rsp_valid, 1'b0);
        tick;
        check("t1_valid", rsp_valid, 1'b1);
        check("t1_data", rsp_data, 8'hA0);
        check("t1_id", rsp_id, 1'b0);

        // stall in RESP with both requesters pushing
        req_valid = 2'b11; d1 = 8'h33; a1 = 6'd0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, 8'hA0);
            check("hold_ready", req_ready, 2'b00);
            tick;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick;
        check("t1_release", rsp_valid, 1'b0);

        // req1 amt 8 -> r=0, response next cycle with data unchanged
        req_valid = 2'b10; d1 = 8'h14; a1 = 6'd8;
        #1;
        check("t2_grant", req_ready, 2'b10);
        tick;
        req_valid = 2'b00;
        #1;
        check("t2_valid", rsp_valid, 1'b1);
        check("t2_data", rsp_data, 8'h14);
        check("t2_id", rsp_id, 1'b1);
        check("t2_load", br_load, 1'b0);
        tick;
        check("t2_done", rsp_valid, 1'b0);

        // req1 amt 11 -> r=3; Rsp_ready high outside RESP is ignored
        req_valid = 2'b10; a1 = 6'd11;
        tick;
        req_valid = 2'b00;
        #1;
        check("t3_load", br_load, 1'b1);
        check("t3_sel", br_sel, 3'd2);
        tick;
        check("t3_capt_valid", rsp_valid, 1'b0);
        tick;
        check("t3_valid", rsp_valid, 1'b1);
        check("t3_data", rsp_data, 8'hA0);
        check("t3_id", rsp_id, 1'b1);
        tick;

        // both valid continuously: grants alternate starting with req0
        req_valid = 2'b11; d0 = 8'h11; d1 = 8'h22; a0 = 6'd0; a1 = 6'd0;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 1) ? 2'b10 : 2'b01;
            ed = (i % 2 == 1) ? 8'h22 : 8'h11;
            #1;
            check("alt_grant", req_ready, eg);
            tick;
            check("alt_valid", rsp_valid, 1'b1);
            check("alt_id", rsp_id, eg[1]);
            check("alt_data", rsp_data, ed);
            tick;
        end
        req_valid = 2'b00;

`ifdef BARREL_SCHED_STATS_EN
        check("stat0", st0, 16'd3);
        check("stat1", st1, 16'd4);
`endif

        // reset asserted while in LOAD
        req_valid = 2'b01; d0 = 8'h14; a0 = 6'd3;
        tick;
        check("t5_load", br_load, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_ready", req_ready, 2'b00);
        check("t5_br_load", br_load, 1'b0);
        check("t5_br_sel", br_sel, 3'd0);
        check("t5_br_din", br_din, 8'h00);
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_rsp_data", rsp_data, 8'h00);
`ifdef BARREL_SCHED_STATS_EN
        check("t5_stat0", st0, 16'd0);
`endif
        tick;
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick;
        req_valid = 2'b10;
        #1;
        check("t5_follow_on", req_ready, 2'b10);
        req_valid = 2'b00;
        #1;
        check("t5_follow_off", req_ready, 2'b00);
        repeat (4) tick;
        check("t5_no_rsp", rsp_valid, 1'b0);

        // SEL_W=2 instance: 0x14 rotl 6 in passes of 4 then 2
        req_valid2 = 2'b01; d02 = 8'h14; a02 = 6'd6;
        tick;
        req_valid2 = 2'b00;
        #1;
        check("s2_p1_load", br_load2, 1'b1);
        check("s2_p1_sel", br_sel2, 2'd3);
        tick;
        check("s2_p2_load", br_load2, 1'b0);
        check("s2_p2_sel", br_sel2, 2'd1);
        tick;
        check("s2_capt_sel", br_sel2, 2'd0);
        check("s2_capt_valid", rsp_valid2, 1'b0);
        tick;
        check("s2_valid", rsp_valid2, 1'b1);
        check("s2_data", rsp_data2, 8'h05);
        check("s2_id", rsp_id2, 1'b0);
        rsp_ready2 = 1'b1;
        tick;
        check("s2_done", rsp_valid2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
